// File: rtl/tl_sink_remapper_pkg.sv
// Shared TileLink channel payload types and helpers for the sink remapper.
// Sink fields travel on separate ports because their width differs per side.
package tl_sink_remapper_pkg;

    localparam int TL_DW       = 64;
    localparam int TL_AW       = 56;
    localparam int TL_SRCW     = 1;
    localparam int TL_SZW      = 3;
    localparam int TL_MAX_SIZE = 6;

    typedef enum logic [2:0] {
        ACCESS_ACK      = 3'd0,
        ACCESS_ACK_DATA = 3'd1,
        HINT_ACK        = 3'd2,
        GRANT           = 3'd4,
        GRANT_DATA      = 3'd5,
        RELEASE_ACK     = 3'd6
    } tl_d_op_e;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [2:0]          param;
        logic [TL_SZW-1:0]   size;
        logic [TL_SRCW-1:0]  source;
        logic [TL_AW-1:0]    address;
        logic [TL_DW/8-1:0]  mask;
        logic [TL_DW-1:0]    data;
        logic                corrupt;
    } tl_a_t;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [1:0]          param;
        logic [TL_SZW-1:0]   size;
        logic [TL_SRCW-1:0]  source;
        logic [TL_AW-1:0]    address;
        logic [TL_DW/8-1:0]  mask;
        logic [TL_DW-1:0]    data;
        logic                corrupt;
    } tl_b_t;

    typedef struct packed {
        logic [2:0]          opcode;
        logic [2:0]          param;
        logic [TL_SZW-1:0]   size;
        logic [TL_SRCW-1:0]  source;
        logic [TL_AW-1:0]    address;
        logic [TL_DW-1:0]    data;
        logic                corrupt;
    } tl_c_t;

    typedef struct packed {
        tl_d_op_e            opcode;
        logic [1:0]          param;
        logic [TL_SZW-1:0]   size;
        logic [TL_SRCW-1:0]  source;
        logic                denied;
        logic [TL_DW-1:0]    data;
        logic                corrupt;
    } tl_d_t;

    // Beats in a data-carrying message of 2**size bytes on a data_width-bit bus.
    function automatic int unsigned tl_beats(input int unsigned size, input int unsigned data_width);
        int unsigned lg;
        lg = $clog2(data_width / 8);
        return (size > lg) ? (32'd1 << (size - lg)) : 32'd1;
    endfunction

    function automatic int tl_slot_width(input int num_slots);
        return (num_slots > 1) ? $clog2(num_slots) : 1;
    endfunction

endpackage

// File: rtl/tl_sink_remapper_alloc.sv
// Host sink slot table: tracks which host slots hold an outstanding grant and
// the device sink each one maps back to.
module tl_sink_alloc
    import tl_sink_remapper_pkg::*;
#(
    parameter int NumSlots        = 2,
    parameter int DeviceSinkWidth = 2,
    parameter int SlotWidth       = tl_slot_width(NumSlots),
    parameter int CntWidth        = $clog2(NumSlots + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       alloc_req,
    output logic                       alloc_gnt,
    output logic [SlotWidth-1:0]       alloc_slot,
    input  logic                       alloc_commit,
    input  logic [DeviceSinkWidth-1:0] alloc_sink,
    input  logic                       free_valid,
    input  logic [SlotWidth-1:0]       free_slot,
    input  logic [SlotWidth-1:0]       lookup_slot,
    output logic [DeviceSinkWidth-1:0] lookup_sink,
    output logic                       lookup_valid,
    output logic [CntWidth-1:0]        slots_free
);

    logic [NumSlots-1:0]        valid_q, valid_d;
    logic [DeviceSinkWidth-1:0] table_q [NumSlots];
    logic [DeviceSinkWidth-1:0] table_d [NumSlots];
    logic                       free_found;
    logic [SlotWidth-1:0]       lowest_free;
    logic [CntWidth-1:0]        used;

    // Descending scan so the last write wins with the lowest free index.
    always_comb begin
        free_found  = 1'b0;
        lowest_free = '0;
        for (int i = NumSlots - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_found  = 1'b1;
                lowest_free = SlotWidth'(i);
            end
        end
    end

    assign alloc_gnt  = alloc_req & free_found;
    assign alloc_slot = lowest_free;

    always_comb begin
        valid_d = valid_q;
        table_d = table_q;
        for (int i = 0; i < NumSlots; i++) begin
            if (alloc_commit && alloc_gnt && (lowest_free == SlotWidth'(i))) begin
                valid_d[i] = 1'b1;
                table_d[i] = alloc_sink;
            end
            if (free_valid && (free_slot == SlotWidth'(i))) begin
                valid_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        lookup_sink  = '0;
        lookup_valid = 1'b0;
        used         = '0;
        for (int i = 0; i < NumSlots; i++) begin
            if (lookup_slot == SlotWidth'(i)) begin
                lookup_sink  = table_q[i];
                lookup_valid = valid_q[i];
            end
            used = used + CntWidth'(valid_q[i]);
        end
        slots_free = CntWidth'(NumSlots) - used;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < NumSlots; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < NumSlots; i++) begin
                table_q[i] <= table_d[i];
            end
        end
    end

endmodule

// File: rtl/tl_sink_remapper.sv
// Remaps TileLink D/E sink IDs between a device-side sink space and a host-side
// slot space; A/B/C pass straight through.
module tl_sink_remapper
    import tl_sink_remapper_pkg::*;
#(
    parameter int DataWidth       = TL_DW,
    parameter int HostSinkWidth   = 1,
    parameter int DeviceSinkWidth = 2,
    parameter int NumSlots        = 2 ** HostSinkWidth,
    parameter int MaxSize         = TL_MAX_SIZE
) (
    input  logic                          clk_i,
    input  logic                          rst_i,

    input  logic                          host_a_valid,
    output logic                          host_a_ready,
    input  tl_a_t                         host_a,
    output logic                          device_a_valid,
    input  logic                          device_a_ready,
    output tl_a_t                         device_a,

    output logic                          host_b_valid,
    input  logic                          host_b_ready,
    output tl_b_t                         host_b,
    input  logic                          device_b_valid,
    output logic                          device_b_ready,
    input  tl_b_t                         device_b,

    input  logic                          host_c_valid,
    output logic                          host_c_ready,
    input  tl_c_t                         host_c,
    output logic                          device_c_valid,
    input  logic                          device_c_ready,
    output tl_c_t                         device_c,

    output logic                          host_d_valid,
    input  logic                          host_d_ready,
    output tl_d_t                         host_d,
    output logic [HostSinkWidth-1:0]      host_d_sink,
    input  logic                          device_d_valid,
    output logic                          device_d_ready,
    input  tl_d_t                         device_d,
    input  logic [DeviceSinkWidth-1:0]    device_d_sink,

    input  logic                          host_e_valid,
    output logic                          host_e_ready,
    input  logic [HostSinkWidth-1:0]      host_e_sink,
    output logic                          device_e_valid,
    input  logic                          device_e_ready,
    output logic [DeviceSinkWidth-1:0]    device_e_sink,

    output logic [$clog2(NumSlots+1)-1:0] slots_free_o
);

    localparam int LgBytes = $clog2(DataWidth / 8);
    localparam int BeatW   = (MaxSize > LgBytes) ? (MaxSize - LgBytes) : 1;
    localparam int SlotW   = tl_slot_width(NumSlots);

    logic [BeatW-1:0]           beat_cnt_q, beat_cnt_d;
    logic [SlotW-1:0]           burst_slot_q, burst_slot_d;
    logic                       d_first, d_is_grant, d_has_data, d_last;
    logic                       alloc_beat, alloc_gnt, d_stall, d_fire;
    logic [SlotW-1:0]           alloc_slot;
    int unsigned                d_beats;
    logic                       e_fire, e_in_range, lookup_valid;
    logic [DeviceSinkWidth-1:0] lookup_sink;

    assign device_a_valid = host_a_valid & ~rst_i;
    assign host_a_ready   = device_a_ready & ~rst_i;
    assign device_a       = host_a;
    assign host_b_valid   = device_b_valid & ~rst_i;
    assign device_b_ready = host_b_ready & ~rst_i;
    assign host_b         = device_b;
    assign device_c_valid = host_c_valid & ~rst_i;
    assign host_c_ready   = device_c_ready & ~rst_i;
    assign device_c       = host_c;

    assign d_first    = (beat_cnt_q == '0);
    assign d_is_grant = (device_d.opcode == GRANT) || (device_d.opcode == GRANT_DATA);
    assign d_has_data = (device_d.opcode == GRANT_DATA) || (device_d.opcode == ACCESS_ACK_DATA);
    assign alloc_beat = device_d_valid & d_first & d_is_grant;

    // A first grant beat with no free slot is held off on both sides at once.
    assign d_stall        = alloc_beat & ~alloc_gnt;
    assign host_d_valid   = device_d_valid & ~d_stall & ~rst_i;
    assign device_d_ready = host_d_ready & ~d_stall & ~rst_i;
    assign d_fire         = device_d_valid & device_d_ready;
    assign host_d         = device_d;

    always_comb begin
        d_beats = d_has_data ? tl_beats(32'(device_d.size), 32'(DataWidth)) : 32'd1;
        d_last  = (32'(beat_cnt_q) == (d_beats - 32'd1));

        beat_cnt_d = beat_cnt_q;
        if (d_fire) begin
            beat_cnt_d = d_last ? '0 : (beat_cnt_q + BeatW'(1));
        end

        burst_slot_d = burst_slot_q;
        if (d_fire && alloc_beat) begin
            burst_slot_d = alloc_slot;
        end

        host_d_sink = '0;
        if (d_is_grant) begin
            host_d_sink = HostSinkWidth'(d_first ? alloc_slot : burst_slot_q);
        end
    end

    assign device_e_valid = host_e_valid & ~rst_i;
    assign host_e_ready   = device_e_ready & ~rst_i;
    assign e_fire         = device_e_valid & device_e_ready;
    assign e_in_range     = (32'(host_e_sink) < 32'(NumSlots));
    assign device_e_sink  = e_in_range ? lookup_sink : '0;

    tl_sink_alloc #(
        .NumSlots        (NumSlots),
        .DeviceSinkWidth (DeviceSinkWidth),
        .SlotWidth       (SlotW),
        .CntWidth        ($clog2(NumSlots + 1))
    ) u_alloc (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .alloc_req    (alloc_beat),
        .alloc_gnt    (alloc_gnt),
        .alloc_slot   (alloc_slot),
        .alloc_commit (d_fire & alloc_beat),
        .alloc_sink   (device_d_sink),
        .free_valid   (e_fire & e_in_range & lookup_valid),
        .free_slot    (SlotW'(host_e_sink)),
        .lookup_slot  (SlotW'(host_e_sink)),
        .lookup_sink  (lookup_sink),
        .lookup_valid (lookup_valid),
        .slots_free   (slots_free_o)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_cnt_q   <= '0;
            burst_slot_q <= '0;
        end else begin
            beat_cnt_q   <= beat_cnt_d;
            burst_slot_q <= burst_slot_d;
        end
    end

    // GrantAck must name a slot that currently holds a grant.
    e_sink_legal: assert property (@(posedge clk_i) disable iff (rst_i)
        e_fire |-> (e_in_range && lookup_valid));

endmodule

// File: tb/tb_tl_sink_remapper.sv
// Directed bench for tl_sink_remapper: a 2-slot narrow-host instance driven from a
// vector table, plus a 4-slot wide-host instance and reset/pass-through sequences.
module tb_tl_sink_remapper;
    import tl_sink_remapper_pkg::*;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic p_ha_valid, p_ha_ready, p_da_valid, p_da_ready;
    tl_a_t p_ha, p_da;
    logic p_hb_valid, p_hb_ready, p_db_valid, p_db_ready;
    tl_b_t p_hb, p_db;
    logic p_hc_valid, p_hc_ready, p_dc_valid, p_dc_ready;
    tl_c_t p_hc, p_dc;
    logic p_hd_valid, p_hd_ready, p_dd_valid, p_dd_ready;
    tl_d_t p_hd, p_dd;
    logic [0:0] p_hd_sink;
    logic [2:0] p_dd_sink;
    logic p_he_valid, p_he_ready, p_de_valid, p_de_ready;
    logic [0:0] p_he_sink;
    logic [2:0] p_de_sink;
    logic [1:0] p_sf;

    logic q_ha_valid, q_ha_ready, q_da_valid, q_da_ready;
    tl_a_t q_ha, q_da;
    logic q_hb_valid, q_hb_ready, q_db_valid, q_db_ready;
    tl_b_t q_hb, q_db;
    logic q_hc_valid, q_hc_ready, q_dc_valid, q_dc_ready;
    tl_c_t q_hc, q_dc;
    logic q_hd_valid, q_hd_ready, q_dd_valid, q_dd_ready;
    tl_d_t q_hd, q_dd;
    logic [2:0] q_hd_sink;
    logic [0:0] q_dd_sink;
    logic q_he_valid, q_he_ready, q_de_valid, q_de_ready;
    logic [2:0] q_he_sink;
    logic [0:0] q_de_sink;
    logic [2:0] q_sf;

    tl_sink_remapper #(.HostSinkWidth(1), .DeviceSinkWidth(3), .NumSlots(2)) u_p (
        .clk_i(clk), .rst_i(rst_i),
        .host_a_valid(p_ha_valid), .host_a_ready(p_ha_ready), .host_a(p_ha),
        .device_a_valid(p_da_valid), .device_a_ready(p_da_ready), .device_a(p_da),
        .host_b_valid(p_hb_valid), .host_b_ready(p_hb_ready), .host_b(p_hb),
        .device_b_valid(p_db_valid), .device_b_ready(p_db_ready), .device_b(p_db),
        .host_c_valid(p_hc_valid), .host_c_ready(p_hc_ready), .host_c(p_hc),
        .device_c_valid(p_dc_valid), .device_c_ready(p_dc_ready), .device_c(p_dc),
        .host_d_valid(p_hd_valid), .host_d_ready(p_hd_ready), .host_d(p_hd), .host_d_sink(p_hd_sink),
        .device_d_valid(p_dd_valid), .device_d_ready(p_dd_ready), .device_d(p_dd), .device_d_sink(p_dd_sink),
        .host_e_valid(p_he_valid), .host_e_ready(p_he_ready), .host_e_sink(p_he_sink),
        .device_e_valid(p_de_valid), .device_e_ready(p_de_ready), .device_e_sink(p_de_sink),
        .slots_free_o(p_sf)
    );

    tl_sink_remapper #(.HostSinkWidth(3), .DeviceSinkWidth(1), .NumSlots(4)) u_q (
        .clk_i(clk), .rst_i(rst_i),
        .host_a_valid(q_ha_valid), .host_a_ready(q_ha_ready), .host_a(q_ha),
        .device_a_valid(q_da_valid), .device_a_ready(q_da_ready), .device_a(q_da),
        .host_b_valid(q_hb_valid), .host_b_ready(q_hb_ready), .host_b(q_hb),
        .device_b_valid(q_db_valid), .device_b_ready(q_db_ready), .device_b(q_db),
        .host_c_valid(q_hc_valid), .host_c_ready(q_hc_ready), .host_c(q_hc),
        .device_c_valid(q_dc_valid), .device_c_ready(q_dc_ready), .device_c(q_dc),
        .host_d_valid(q_hd_valid), .host_d_ready(q_hd_ready), .host_d(q_hd), .host_d_sink(q_hd_sink),
        .device_d_valid(q_dd_valid), .device_d_ready(q_dd_ready), .device_d(q_dd), .device_d_sink(q_dd_sink),
        .host_e_valid(q_he_valid), .host_e_ready(q_he_ready), .host_e_sink(q_he_sink),
        .device_e_valid(q_de_valid), .device_e_ready(q_de_ready), .device_e_sink(q_de_sink),
        .slots_free_o(q_sf)
    );

    typedef struct {
        logic       dv;
        tl_d_op_e   op;
        logic [2:0] sz;
        logic [2:0] ds;
        logic       hr;
        logic       ev;
        logic       es;
        logic       hv;
        logic       dr;
        logic       hs;
        logic [2:0] xes;
        logic [1:0] sf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic dv, tl_d_op_e op, int sz, int ds, logic hr, logic ev, logic es,
                                logic hv, logic dr, logic hs, int xes, int sf);
        vec_t v;
        v.dv = dv;  v.op = op;  v.sz = 3'(sz);  v.ds = 3'(ds);  v.hr = hr;
        v.ev = ev;  v.es = es;  v.hv = hv;  v.dr = dr;  v.hs = hs;
        v.xes = 3'(xes);  v.sf = 2'(sf);
        return v;
    endfunction

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_all();
        p_ha_valid = 0; p_ha = '0; p_da_ready = 0; p_hb_ready = 0; p_db_valid = 0; p_db = '0;
        p_hc_valid = 0; p_hc = '0; p_dc_ready = 0;
        p_dd_valid = 0; p_dd = '0; p_dd_sink = '0; p_hd_ready = 1;
        p_he_valid = 0; p_he_sink = '0; p_de_ready = 1;
        q_ha_valid = 0; q_ha = '0; q_da_ready = 0; q_hb_ready = 0; q_db_valid = 0; q_db = '0;
        q_hc_valid = 0; q_hc = '0; q_dc_ready = 0;
        q_dd_valid = 0; q_dd = '0; q_dd_sink = '0; q_hd_ready = 1;
        q_he_valid = 0; q_he_sink = '0; q_de_ready = 1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Test 1: 8-beat GrantData, then GrantAck.
        vecs.push_back(mk(1, GRANT_DATA, 6, 3, 1, 0, 0, 1, 1, 0, 0, 2));
        for (int i = 0; i < 7; i++) vecs.push_back(mk(1, GRANT_DATA, 6, 3, 1, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, ACCESS_ACK, 0, 0, 1, 1, 0, 0, 1, 0, 3, 1));
        vecs.push_back(mk(0, ACCESS_ACK, 0, 0, 1, 0, 0, 0, 1, 0, 0, 2));
        // Test 2: fill both slots.
        vecs.push_back(mk(1, GRANT, 0, 5, 1, 0, 0, 1, 1, 0, 0, 2));
        vecs.push_back(mk(0, ACCESS_ACK, 0, 0, 1, 1, 0, 0, 1, 0, 5, 1));
        vecs.push_back(mk(1, GRANT, 0, 5, 1, 0, 0, 1, 1, 0, 0, 2));
        vecs.push_back(mk(1, GRANT, 0, 7, 1, 0, 0, 1, 1, 1, 0, 1));
        // Test 4: AccessAckData burst while full, one back-pressured beat.
        vecs.push_back(mk(1, ACCESS_ACK_DATA, 6, 0, 1, 0, 0, 1, 1, 0, 0, 0));
        vecs.push_back(mk(1, ACCESS_ACK_DATA, 6, 0, 0, 0, 0, 1, 0, 0, 0, 0));
        for (int i = 0; i < 7; i++) vecs.push_back(mk(1, ACCESS_ACK_DATA, 6, 0, 1, 0, 0, 1, 1, 0, 0, 0));
        // Third grant stalls, E frees slot 1 in the same cycle, grant lands next cycle.
        vecs.push_back(mk(1, GRANT, 0, 6, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, GRANT, 0, 6, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1, GRANT, 0, 6, 1, 1, 1, 0, 0, 0, 7, 0));
        vecs.push_back(mk(1, GRANT, 0, 6, 1, 0, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk(0, ACCESS_ACK, 0, 0, 1, 1, 1, 0, 1, 0, 6, 0));
        vecs.push_back(mk(0, ACCESS_ACK, 0, 0, 1, 1, 0, 0, 1, 0, 5, 1));
        vecs.push_back(mk(0, ACCESS_ACK, 0, 0, 1, 0, 0, 0, 1, 0, 0, 2));
        // Single-beat messages regardless of size field / size at bus width.
        vecs.push_back(mk(1, RELEASE_ACK, 6, 0, 1, 0, 0, 1, 1, 0, 0, 2));
        vecs.push_back(mk(1, GRANT, 0, 2, 1, 0, 0, 1, 1, 0, 0, 2));
        vecs.push_back(mk(1, GRANT_DATA, 3, 4, 1, 0, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk(1, GRANT, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, ACCESS_ACK, 0, 0, 1, 1, 0, 0, 1, 0, 2, 0));
        vecs.push_back(mk(0, ACCESS_ACK, 0, 0, 1, 1, 1, 0, 1, 0, 4, 1));
        vecs.push_back(mk(0, ACCESS_ACK, 0, 0, 1, 0, 0, 0, 1, 0, 0, 2));
        // Test 3: same-cycle free of slot 0 while full; grant takes slot 0 one cycle later.
        vecs.push_back(mk(1, GRANT, 0, 1, 1, 0, 0, 1, 1, 0, 0, 2));
        vecs.push_back(mk(1, GRANT, 0, 2, 1, 0, 0, 1, 1, 1, 0, 1));
        vecs.push_back(mk(1, GRANT, 0, 3, 1, 1, 0, 0, 0, 0, 1, 0));
        vecs.push_back(mk(1, GRANT, 0, 3, 1, 0, 0, 1, 1, 0, 0, 1));
        vecs.push_back(mk(0, ACCESS_ACK, 0, 0, 1, 1, 1, 0, 1, 0, 2, 0));
        vecs.push_back(mk(0, ACCESS_ACK, 0, 0, 1, 1, 0, 0, 1, 0, 3, 1));
        vecs.push_back(mk(0, ACCESS_ACK, 0, 0, 1, 0, 0, 0, 1, 0, 0, 2));

        // Reset state and output gating.
        idle_all();
        p_dd_valid = 1; p_dd.opcode = GRANT; p_he_valid = 1; p_ha_valid = 1; p_da_ready = 1;
        repeat (2) @(posedge clk);
        #2;
        chk("rst host_d_valid", 256'(p_hd_valid), 256'(0));
        chk("rst device_d_ready", 256'(p_dd_ready), 256'(0));
        chk("rst device_e_valid", 256'(p_de_valid), 256'(0));
        chk("rst host_e_ready", 256'(p_he_ready), 256'(0));
        chk("rst device_a_valid", 256'(p_da_valid), 256'(0));
        chk("rst p slots_free", 256'(p_sf), 256'(2));
        chk("rst q slots_free", 256'(q_sf), 256'(4));
        idle_all();
        next_cycle();
        rst_i = 0;

        for (int i = 0; i < vecs.size(); i++) begin
            p_dd_valid = vecs[i].dv;  p_dd.opcode = vecs[i].op;  p_dd.size = vecs[i].sz;
            p_dd_sink = vecs[i].ds;   p_hd_ready = vecs[i].hr;
            p_he_valid = vecs[i].ev;  p_he_sink = vecs[i].es;
            #2;
            chk($sformatf("v%0d host_d_valid", i), 256'(p_hd_valid), 256'(vecs[i].hv));
            chk($sformatf("v%0d device_d_ready", i), 256'(p_dd_ready), 256'(vecs[i].dr));
            if (vecs[i].dv && vecs[i].hv)
                chk($sformatf("v%0d host_d_sink", i), 256'(p_hd_sink), 256'(vecs[i].hs));
            if (vecs[i].ev)
                chk($sformatf("v%0d device_e_sink", i), 256'(p_de_sink), 256'(vecs[i].xes));
            chk($sformatf("v%0d device_e_valid", i), 256'(p_de_valid), 256'(vecs[i].ev));
            chk($sformatf("v%0d slots_free", i), 256'(p_sf), 256'(vecs[i].sf));
            next_cycle();
        end
        idle_all();

        // A/B/C pass-through and D payload copy on the first beat of a burst.
        p_ha_valid = 1; p_ha.opcode = 3'd4; p_ha.address = 56'h12_3456_789A_BCDE;
        p_ha.data = 64'hDEAD_BEEF_0123_4567; p_ha.mask = 8'hF0; p_ha.source = 1'b1; p_da_ready = 1;
        p_db_valid = 1; p_db.address = 56'h00_0000_0000_1040; p_db.param = 2'd2; p_hb_ready = 1;
        p_hc_valid = 1; p_hc.data = 64'h0F0F_1234_5678_9ABC; p_hc.opcode = 3'd7; p_dc_ready = 1;
        p_dd_valid = 1; p_dd.opcode = GRANT_DATA; p_dd.size = 3'd6; p_dd.data = 64'hCAFE_F00D_1111_2222;
        p_dd.param = 2'd1; p_dd_sink = 3'd3;
        #2;
        chk("a valid", 256'(p_da_valid), 256'(1));
        chk("a ready", 256'(p_ha_ready), 256'(1));
        chk("a payload", 256'(p_da), 256'(p_ha));
        chk("b valid", 256'(p_hb_valid), 256'(1));
        chk("b ready", 256'(p_db_ready), 256'(1));
        chk("b payload", 256'(p_hb), 256'(p_db));
        chk("c valid", 256'(p_dc_valid), 256'(1));
        chk("c ready", 256'(p_hc_ready), 256'(1));
        chk("c payload", 256'(p_dc), 256'(p_hc));
        chk("d payload", 256'(p_hd), 256'(p_dd));
        chk("burst b0 sink", 256'(p_hd_sink), 256'(0));
        next_cycle();
        next_cycle();
        #2;
        chk("burst b2 slots_free", 256'(p_sf), 256'(1));
        next_cycle();

        // Test 6: reset mid-burst.
        rst_i = 1;
        p_he_valid = 1;
        #2;
        chk("mid rst host_d_valid", 256'(p_hd_valid), 256'(0));
        chk("mid rst device_d_ready", 256'(p_dd_ready), 256'(0));
        chk("mid rst device_e_valid", 256'(p_de_valid), 256'(0));
        chk("mid rst host_e_ready", 256'(p_he_ready), 256'(0));
        chk("mid rst a valid", 256'(p_da_valid), 256'(0));
        chk("mid rst b valid", 256'(p_hb_valid), 256'(0));
        chk("mid rst c ready", 256'(p_hc_ready), 256'(0));
        next_cycle();
        rst_i = 0;
        idle_all();
        p_dd_valid = 1; p_dd.opcode = GRANT; p_dd_sink = 3'd5;
        #2;
        chk("post rst slots_free", 256'(p_sf), 256'(2));
        chk("post rst grant valid", 256'(p_hd_valid), 256'(1));
        chk("post rst grant sink", 256'(p_hd_sink), 256'(0));
        next_cycle();
        p_dd_valid = 0;
        #2;
        chk("post rst alloc slots_free", 256'(p_sf), 256'(1));
        p_he_valid = 1; p_he_sink = 1'b0;
        #1;
        chk("post rst e sink", 256'(p_de_sink), 256'(5));
        next_cycle();
        p_he_valid = 0;
        #2;
        chk("post rst freed", 256'(p_sf), 256'(2));

        // Test 5: wide host, 1-bit device sink, four slots.
        for (int i = 0; i < 4; i++) begin
            q_dd_valid = 1; q_dd.opcode = GRANT; q_dd_sink = 1'b1;
            #2;
            chk($sformatf("q grant%0d valid", i), 256'(q_hd_valid), 256'(1));
            chk($sformatf("q grant%0d sink", i), 256'(q_hd_sink), 256'(i));
            chk($sformatf("q grant%0d slots_free", i), 256'(q_sf), 256'(4 - i));
            next_cycle();
        end
        #2;
        chk("q full host_d_valid", 256'(q_hd_valid), 256'(0));
        chk("q full device_d_ready", 256'(q_dd_ready), 256'(0));
        chk("q full slots_free", 256'(q_sf), 256'(0));
        q_dd_valid = 0;
        for (int i = 0; i < 4; i++) begin
            q_he_valid = 1; q_he_sink = 3'(i);
            #2;
            chk($sformatf("q e%0d sink", i), 256'(q_de_sink), 256'(1));
            chk($sformatf("q e%0d slots_free", i), 256'(q_sf), 256'(i));
            next_cycle();
        end
        q_he_valid = 0;
        #2;
        chk("q end slots_free", 256'(q_sf), 256'(4));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
